// File: rtl/conv_window_gen.sv
// conv_window_gen: turns a raster pixel stream into packed 3x3 windows for the conv core.
// Latency: 1 cycle from accepting pixel (r,c), r>=2 and c>=2, to its window on o_window.
// Backpressure: one output register; o_ready = !o_valid || i_ready, so a stalled window blocks input.
// Ports: i_clk/i_rstn clock and async active-low reset; i_pixel/i_valid/o_ready pixel input;
//        o_window/o_valid/i_ready/o_last window output (slot k=3i+j holds pixel (r-2+i, c-2+j)).
module conv_window_gen #(
    parameter int DATA_W = 10,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [DATA_W-1:0]     i_pixel,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [9*DATA_W-1:0]   o_window,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_last
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [DATA_W-1:0]    lb1_q [IMG_W];   // line r-1
    logic [DATA_W-1:0]    lb2_q [IMG_W];   // line r-2
    logic [DATA_W-1:0]    sr_q  [9];       // same slot layout as the output window
    logic [DATA_W-1:0]    sr_d  [9];
    logic [9*DATA_W-1:0]  window_q, window_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 accept;
    logic                 load;

    assign o_ready  = !valid_q || i_ready;
    assign accept   = i_valid && o_ready;
    assign o_window = window_q;
    assign o_valid  = valid_q;
    assign o_last   = last_q;

    always_comb begin
        sr_d     = sr_q;
        col_d    = col_q;
        row_d    = row_q;
        window_d = window_q;
        last_d   = last_q;
        valid_d  = valid_q;
        load     = 1'b0;

        if (accept) begin
            // Shift every row one column left, then drop in the new column c.
            for (int i = 0; i < 3; i++) begin
                sr_d[3*i]     = sr_q[3*i + 1];
                sr_d[3*i + 1] = sr_q[3*i + 2];
            end
            sr_d[2] = lb2_q[col_q];
            sr_d[5] = lb1_q[col_q];
            sr_d[8] = i_pixel;

            // Columns 0 and 1 of the current line have shifted in before c reaches 2,
            // so the previous line's tail never appears in an emitted window.
            load = (row_q >= RW'(2)) && (col_q >= CW'(2));

            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end

        if (load) begin
            for (int k = 0; k < 9; k++) begin
                window_d[DATA_W*k +: DATA_W] = sr_d[k];
            end
            last_d  = (row_q == ROW_MAX) && (col_q == COL_MAX);
            valid_d = 1'b1;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            col_q    <= '0;
            row_q    <= '0;
            window_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                sr_q[k] <= '0;
            end
        end else begin
            col_q    <= col_d;
            row_q    <= row_d;
            window_q <= window_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            sr_q     <= sr_d;
        end
    end

    // Line buffer contents need no reset: rows 0 and 1 of every frame rewrite them
    // before any window reads them.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb2_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= i_pixel;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;

    localparam int DW = 10;
    localparam int WB = 9 * DW;
    localparam int W  = 4;
    localparam int H  = 4;

    typedef struct {
        logic [WB-1:0] win;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small 4x4 instance
    logic          rstn;
    logic [DW-1:0] i_pixel;
    logic          i_valid;
    logic          o_ready;
    logic [WB-1:0] o_window;
    logic          o_valid;
    logic          i_ready;
    logic          o_last;

    // Default-size instance, all-ones stream
    logic          rstn_b;
    logic [DW-1:0] b_pixel;
    logic          b_vld_i;
    logic          b_rdy_o;
    logic [WB-1:0] b_window;
    logic          b_vld_o;
    logic          b_rdy_i;
    logic          b_last;

    conv_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_pixel (i_pixel),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_window(o_window),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_last  (o_last)
    );

    conv_window_gen #(.DATA_W(DW), .IMG_W(32), .IMG_H(32)) dut_b (
        .i_clk   (clk),
        .i_rstn  (rstn_b),
        .i_pixel (b_pixel),
        .i_valid (b_vld_i),
        .o_ready (b_rdy_o),
        .o_window(b_window),
        .o_valid (b_vld_o),
        .i_ready (b_rdy_i),
        .o_last  (b_last)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Window whose top-left pixel value is tl, for a ramp stream of line width W.
    function automatic logic [WB-1:0] ramp_win(input int tl);
        logic [WB-1:0] w;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            w[DW*k +: DW] = DW'(tl + W*(k/3) + (k%3));
        end
        return w;
    endfunction

    // ---------------- reference model + scoreboard (4x4 instance) ----------------
    int            img [H][W];
    int            mr, mc;
    exp_t          exp_q [$];
    logic [WB-1:0] rx_q  [$];
    int            n_win, n_last;

    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            exp_q.delete();
            mr = 0;
            mc = 0;
        end else begin
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_window", 90'(1), 90'(0));
                end else begin
                    chk("window", o_window, exp_q[0].win);
                    chk("last", 90'(o_last), 90'(exp_q[0].last));
                    if (!i_ready) begin
                        chk("ready_in_stall", 90'(o_ready), 90'(0));
                    end else begin
                        rx_q.push_back(o_window);
                        n_win++;
                        if (o_last) n_last++;
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (i_valid && o_ready) begin
                img[mr][mc] = int'(i_pixel);
                if (mr >= 2 && mc >= 2) begin
                    exp_t e;
                    e.win = '0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e.win[DW*(3*i+j) +: DW] = DW'(img[mr-2+i][mc-2+j]);
                    e.last = (mr == H-1) && (mc == W-1);
                    exp_q.push_back(e);
                end
                mc++;
                if (mc == W) begin
                    mc = 0;
                    mr = (mr + 1) % H;
                end
            end
        end
    end

    // Drive n_pix ramp pixels starting at base; vld_pct/rdy_pct give random gaps,
    // stall_len forces one i_ready=0 burst once a window is pending.
    task automatic drive(input int n_pix, input int base, input int vld_pct,
                         input int rdy_pct, input int stall_len);
        int  idx = 0;
        int  cyc = 0;
        int  stall_rem = 0;
        bit  stalled = 0;
        bit  acc;
        while (idx < n_pix && cyc < 2000) begin
            if (stall_len > 0 && !stalled && o_valid) begin
                stall_rem = stall_len;
                stalled   = 1;
            end
            i_valid = ($urandom_range(99) < vld_pct);
            i_pixel = DW'(base + idx);
            if (stall_rem > 0) begin
                i_ready = 1'b0;
                stall_rem--;
            end else begin
                i_ready = ($urandom_range(99) < rdy_pct);
            end
            @(negedge clk);
            acc = i_valid && o_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
            cyc++;
        end
        if (idx != n_pix) chk("drive_timeout", 90'(idx), 90'(n_pix));
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_test();
        n_win  = 0;
        n_last = 0;
        rx_q.delete();
    endtask

    task automatic end_test(input string tag, input int wins, input int lasts);
        chk({tag, "_count"}, 90'(n_win), 90'(wins));
        chk({tag, "_lasts"}, 90'(n_last), 90'(lasts));
        chk({tag, "_pending"}, 90'(exp_q.size()), 90'(0));
    endtask

    // ---------------- default-size instance ----------------
    int b_acc   = 0;
    int b_nwin  = 0;
    int b_nlast = 0;
    bit b_done  = 0;

    always @(negedge clk) begin
        if (rstn_b) begin
            if (b_vld_o && b_rdy_i) begin
                chk("b_window", b_window, {WB{1'b1}});
                b_nwin++;
                if (b_last) b_nlast++;
            end
            if (b_vld_i && b_rdy_o) b_acc++;
        end
    end

    initial begin
        int guard = 0;
        b_pixel = '1;
        b_vld_i = 1'b0;
        b_rdy_i = 1'b1;
        wait (rstn_b === 1'b1);
        @(posedge clk);
        #1;
        b_vld_i = 1'b1;
        while (b_acc < 1024 && guard < 3000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        b_vld_i = 1'b0;
        repeat (4) @(posedge clk);
        b_done = 1;
    end

    // ---------------- main sequence ----------------
    initial begin
        int g = 0;
        rstn    = 1'b0;
        rstn_b  = 1'b0;
        i_pixel = '0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        #12;
        chk("rst_valid", 90'(o_valid), 90'(0));
        chk("rst_window", o_window, 90'(0));
        chk("rst_last", 90'(o_last), 90'(0));
        chk("rst_ready", 90'(o_ready), 90'(1));
        @(posedge clk);
        #1;
        rstn   = 1'b1;
        rstn_b = 1'b1;

        // Full-rate single frame
        start_test();
        drive(16, 0, 100, 100, 0);
        end_test("basic", 4, 1);
        if (rx_q.size() > 0) chk("basic_first", rx_q[0], ramp_win(0));
        if (rx_q.size() > 3) chk("basic_fourth", rx_q[3], ramp_win(5));

        // Output stall of 3 cycles
        start_test();
        drive(16, 0, 100, 100, 3);
        end_test("stall", 4, 1);
        if (rx_q.size() > 0) chk("stall_first", rx_q[0], ramp_win(0));

        // Random input gaps
        start_test();
        drive(16, 0, 50, 100, 0);
        end_test("gaps", 4, 1);

        // Random gaps on both sides, different pixel values
        start_test();
        drive(16, 300, 60, 60, 0);
        end_test("both_gaps", 4, 1);

        // Two back-to-back frames
        start_test();
        drive(32, 0, 100, 100, 0);
        end_test("b2b", 8, 2);
        if (rx_q.size() > 4) chk("b2b_second_first", rx_q[4], ramp_win(16));

        // Reset mid-frame after 7 accepted pixels
        start_test();
        drive(7, 200, 100, 100, 0);
        #1;
        rstn = 1'b0;
        #1;
        chk("midrst_valid", 90'(o_valid), 90'(0));
        chk("midrst_window", o_window, 90'(0));
        chk("midrst_last", 90'(o_last), 90'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        start_test();
        drive(16, 0, 100, 100, 0);
        end_test("after_rst", 4, 1);
        if (rx_q.size() > 0) chk("after_rst_first", rx_q[0], ramp_win(0));

        while (!b_done && g < 5000) begin
            @(posedge clk);
            g++;
        end
        chk("b_done", 90'(b_done), 90'(1));
        chk("b_count", 90'(b_nwin), 90'(900));
        chk("b_lasts", 90'(b_nlast), 90'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
